// File: rtl/operand_collector_unit.sv
// Single-entry operand collector: latches one dispatched instruction, fetches its source
// registers over a request/response RF port, then offers the assembled instruction to the EUs.
package bgpu_pkg;
  typedef struct packed {
    logic [3:0] eu;
    logic [3:0] op;
    logic [7:0] imm;
  } inst_t;
endpackage

// One operand slot: tracks requested/collected state and holds the returned data.
module opc_slot #(
  parameter int DataW = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clear,
  input  logic             i_req_hs,
  input  logic             i_rsp_hit,
  input  logic [DataW-1:0] i_rsp_data,
  output logic [DataW-1:0] o_data,
  output logic             o_requested,
  output logic             o_collected
);
  logic [DataW-1:0] r_data;
  logic             r_req;
  logic             r_col;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_req  <= 1'b0;
      r_col  <= 1'b0;
    end else if (i_clear) begin
      r_data <= '0;
      r_req  <= 1'b0;
      r_col  <= 1'b0;
    end else begin
      if (i_req_hs) r_req <= 1'b1;
      if (i_rsp_hit) begin
        r_col  <= 1'b1;
        r_data <= i_rsp_data;
      end
    end
  end

  assign o_data      = r_data;
  assign o_requested = r_req;
  assign o_collected = r_col;
endmodule

module operand_collector_unit import bgpu_pkg::*; #(
  parameter  int NumTags         = 8,
  parameter  int PcWidth         = 32,
  parameter  int WarpWidth       = 32,
  parameter  int RegIdxWidth     = 6,
  parameter  int RegWidth        = 32,
  parameter  int OperandsPerInst = 2,
  localparam int TagWidth        = $clog2(NumTags),
  localparam int OpDataWidth     = WarpWidth * RegWidth,
  localparam int OpIdxWidth      = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  output logic                                            opc_ready_o,
  input  logic                                            disp_valid_i,
  input  logic [TagWidth-1:0]                             disp_tag_i,
  input  logic [PcWidth-1:0]                              disp_pc_i,
  input  logic [WarpWidth-1:0]                            disp_act_mask_i,
  input  inst_t                                           disp_inst_i,
  input  logic [RegIdxWidth-1:0]                          disp_dst_i,
  input  logic [OperandsPerInst-1:0]                      disp_operands_required_i,
  input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]     disp_operands_i,
  output logic                                            rf_req_valid_o,
  input  logic                                            rf_req_ready_i,
  output logic [RegIdxWidth-1:0]                          rf_req_reg_o,
  output logic [OpIdxWidth-1:0]                           rf_req_operand_o,
  input  logic                                            rf_rsp_valid_i,
  input  logic [OpIdxWidth-1:0]                           rf_rsp_operand_i,
  input  logic [OpDataWidth-1:0]                          rf_rsp_data_i,
  output logic                                            eu_valid_o,
  input  logic                                            eu_ready_i,
  output logic [TagWidth-1:0]                             eu_tag_o,
  output logic [PcWidth-1:0]                              eu_pc_o,
  output logic [WarpWidth-1:0]                            eu_act_mask_o,
  output inst_t                                           eu_inst_o,
  output logic [RegIdxWidth-1:0]                          eu_dst_o,
  output logic [OperandsPerInst-1:0][OpDataWidth-1:0]     eu_operands_o
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE} state_e;

  state_e r_state, w_state_nxt;

  logic [TagWidth-1:0]                         r_tag;
  logic [PcWidth-1:0]                          r_pc;
  logic [WarpWidth-1:0]                        r_mask;
  inst_t                                       r_inst;
  logic [RegIdxWidth-1:0]                      r_dst;
  logic [OperandsPerInst-1:0]                  r_req_op;
  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] r_operands;

  logic                       w_accept;
  logic [OperandsPerInst-1:0] w_requested;
  logic [OperandsPerInst-1:0] w_collected;
  logic [OperandsPerInst-1:0] w_pend;
  logic [OperandsPerInst-1:0] w_rsp_hit;
  logic [OpIdxWidth-1:0]      w_req_slot;
  logic                       w_req_hs;
  logic                       w_rsp_in_range;
  logic                       w_rsp_ok;
  logic                       w_done;

  assign w_accept       = (r_state == S_IDLE) && disp_valid_i;
  assign w_pend         = r_req_op & ~w_requested;
  assign w_req_hs       = rf_req_valid_o && rf_req_ready_i;
  assign w_rsp_in_range = {1'b0, rf_rsp_operand_i} < (OpIdxWidth+1)'(OperandsPerInst);
  assign w_rsp_ok       = (r_state == S_COLLECT) && rf_rsp_valid_i && w_rsp_in_range;
  // A response arriving this cycle counts toward completion.
  assign w_done         = ((w_collected | w_rsp_hit) & r_req_op) == r_req_op;

  // Lowest-indexed outstanding slot wins the request port.
  always_comb begin
    w_req_slot = '0;
    for (int i = OperandsPerInst - 1; i >= 0; i--)
      if (w_pend[i]) w_req_slot = OpIdxWidth'(i);
  end

  assign rf_req_reg_o     = r_operands[w_req_slot];
  assign rf_req_operand_o = w_req_slot;

  for (genvar g = 0; g < OperandsPerInst; g++) begin : g_slot
    assign w_rsp_hit[g] = w_rsp_ok && (rf_rsp_operand_i == OpIdxWidth'(g))
                          && r_req_op[g] && !w_collected[g];
    opc_slot #(.DataW(OpDataWidth)) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_clear     (w_accept),
      .i_req_hs    (w_req_hs && (w_req_slot == OpIdxWidth'(g))),
      .i_rsp_hit   (w_rsp_hit[g]),
      .i_rsp_data  (rf_rsp_data_i),
      .o_data      (eu_operands_o[g]),
      .o_requested (w_requested[g]),
      .o_collected (w_collected[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (disp_valid_i) w_state_nxt = |disp_operands_required_i ? S_COLLECT : S_ISSUE;
      S_COLLECT: if (w_done)       w_state_nxt = S_ISSUE;
      S_ISSUE:   if (eu_ready_i)   w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    opc_ready_o    = (r_state == S_IDLE);
    eu_valid_o     = (r_state == S_ISSUE);
    rf_req_valid_o = (r_state == S_COLLECT) && |w_pend;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tag      <= '0;
      r_pc       <= '0;
      r_mask     <= '0;
      r_inst     <= '0;
      r_dst      <= '0;
      r_req_op   <= '0;
      r_operands <= '0;
    end else if (w_accept) begin
      r_tag      <= disp_tag_i;
      r_pc       <= disp_pc_i;
      r_mask     <= disp_act_mask_i;
      r_inst     <= disp_inst_i;
      r_dst      <= disp_dst_i;
      r_req_op   <= disp_operands_required_i;
      r_operands <= disp_operands_i;
    end
  end

  assign eu_tag_o      = r_tag;
  assign eu_pc_o       = r_pc;
  assign eu_act_mask_o = r_mask;
  assign eu_inst_o     = r_inst;
  assign eu_dst_o      = r_dst;

  a_rsp_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               rf_rsp_valid_i |-> w_rsp_in_range);
endmodule

// File: tb/tb_operand_collector_unit.sv
// Directed bench for operand_collector_unit: a transaction-level model checked every cycle,
// plus literal expectations on the scenarios of interest.
module tb_operand_collector_unit;
  import bgpu_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             opc_ready_o;
  logic             disp_valid_i;
  logic [2:0]       disp_tag_i;
  logic [31:0]      disp_pc_i;
  logic [31:0]      disp_act_mask_i;
  inst_t            disp_inst_i;
  logic [5:0]       disp_dst_i;
  logic [1:0]       disp_operands_required_i;
  logic [1:0][5:0]  disp_operands_i;
  logic             rf_req_valid_o;
  logic             rf_req_ready_i;
  logic [5:0]       rf_req_reg_o;
  logic [0:0]       rf_req_operand_o;
  logic             rf_rsp_valid_i;
  logic [0:0]       rf_rsp_operand_i;
  logic [1023:0]    rf_rsp_data_i;
  logic             eu_valid_o;
  logic             eu_ready_i;
  logic [2:0]       eu_tag_o;
  logic [31:0]      eu_pc_o;
  logic [31:0]      eu_act_mask_o;
  inst_t            eu_inst_o;
  logic [5:0]       eu_dst_o;
  logic [1:0][1023:0] eu_operands_o;

  operand_collector_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opc_ready_o(opc_ready_o),
    .disp_valid_i(disp_valid_i), .disp_tag_i(disp_tag_i), .disp_pc_i(disp_pc_i),
    .disp_act_mask_i(disp_act_mask_i), .disp_inst_i(disp_inst_i), .disp_dst_i(disp_dst_i),
    .disp_operands_required_i(disp_operands_required_i), .disp_operands_i(disp_operands_i),
    .rf_req_valid_o(rf_req_valid_o), .rf_req_ready_i(rf_req_ready_i),
    .rf_req_reg_o(rf_req_reg_o), .rf_req_operand_o(rf_req_operand_o),
    .rf_rsp_valid_i(rf_rsp_valid_i), .rf_rsp_operand_i(rf_rsp_operand_i),
    .rf_rsp_data_i(rf_rsp_data_i), .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i),
    .eu_tag_o(eu_tag_o), .eu_pc_o(eu_pc_o), .eu_act_mask_o(eu_act_mask_o),
    .eu_inst_o(eu_inst_o), .eu_dst_o(eu_dst_o), .eu_operands_o(eu_operands_o)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got[127:0]=%0h exp[127:0]=%0h", nm, $time, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [1023:0] mk(input logic [31:0] w);
    return {32{w}};
  endfunction

  // Model: one held instruction, the set of slots still to request/collect, and their data.
  logic             m_busy;
  logic [2:0]       m_tag;
  logic [31:0]      m_pc, m_mask;
  inst_t            m_inst;
  logic [5:0]       m_dst;
  logic [1:0]       m_req, m_rqd, m_have;
  logic [1:0][5:0]  m_reg;
  logic [1:0][1023:0] m_data;
  logic             e_done, e_rfv, e_euv;
  logic [0:0]       e_slot;

  always_comb begin
    e_done = (m_have & m_req) == m_req;
    e_rfv  = m_busy && !e_done && |(m_req & ~m_rqd);
    e_euv  = m_busy && e_done;
    e_slot = (m_req[0] && !m_rqd[0]) ? 1'b0 : 1'b1;
  end

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_busy <= 1'b0; m_tag <= '0; m_pc <= '0; m_mask <= '0; m_inst <= '0; m_dst <= '0;
      m_req <= '0; m_rqd <= '0; m_have <= '0; m_reg <= '0; m_data <= '0;
    end else if (!m_busy) begin
      if (disp_valid_i) begin
        m_busy <= 1'b1; m_tag <= disp_tag_i; m_pc <= disp_pc_i; m_mask <= disp_act_mask_i;
        m_inst <= disp_inst_i; m_dst <= disp_dst_i; m_req <= disp_operands_required_i;
        m_reg <= disp_operands_i; m_rqd <= '0; m_have <= '0; m_data <= '0;
      end
    end else if (!e_done) begin
      if (e_rfv && rf_req_ready_i) m_rqd[e_slot] <= 1'b1;
      if (rf_rsp_valid_i && m_req[rf_rsp_operand_i] && !m_have[rf_rsp_operand_i]) begin
        m_have[rf_rsp_operand_i] <= 1'b1;
        m_data[rf_rsp_operand_i] <= rf_rsp_data_i;
      end
    end else if (eu_ready_i) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("m_opc_ready", 64'(opc_ready_o), 64'(!m_busy));
      chk("m_rf_valid", 64'(rf_req_valid_o), 64'(e_rfv));
      chk("m_eu_valid", 64'(eu_valid_o), 64'(e_euv));
      if (e_rfv) begin
        chk("m_rf_reg", 64'(rf_req_reg_o), 64'(m_reg[e_slot]));
        chk("m_rf_slot", 64'(rf_req_operand_o), 64'(e_slot));
      end
      if (e_euv) begin
        chk("m_eu_tag", 64'(eu_tag_o), 64'(m_tag));
        chk("m_eu_pc", 64'(eu_pc_o), 64'(m_pc));
        chk("m_eu_mask", 64'(eu_act_mask_o), 64'(m_mask));
        chk("m_eu_inst", 64'(eu_inst_o), 64'(m_inst));
        chk("m_eu_dst", 64'(eu_dst_o), 64'(m_dst));
        chkd("m_eu_op0", eu_operands_o[0], m_data[0]);
        chkd("m_eu_op1", eu_operands_o[1], m_data[1]);
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input logic [2:0] tag, input logic [31:0] pc, input logic [1:0] req,
                      input logic [5:0] r0, input logic [5:0] r1);
    disp_valid_i             = 1'b1;
    disp_tag_i               = tag;
    disp_pc_i                = pc;
    disp_act_mask_i          = ~pc;
    disp_inst_i              = inst_t'({4'h2, pc[3:0], 8'h5a});
    disp_dst_i               = r0 ^ r1 ^ 6'h21;
    disp_operands_required_i = req;
    disp_operands_i[0]       = r0;
    disp_operands_i[1]       = r1;
  endtask

  task automatic rsp(input logic v, input logic [0:0] op, input logic [31:0] w);
    rf_rsp_valid_i   = v;
    rf_rsp_operand_i = op;
    rf_rsp_data_i    = mk(w);
  endtask

  initial begin
    rst_ni = 1'b0; eu_ready_i = 1'b0; rf_req_ready_i = 1'b0;
    disp(3'd0, 32'h0, 2'b00, 6'd0, 6'd0);
    disp_valid_i = 1'b0;
    rsp(1'b0, 1'b0, 32'h0);

    // reset held three cycles
    repeat (3) begin
      tick; chk_en = 1'b1;
      chk("rst_opc_ready", 64'(opc_ready_o), 64'd1);
      chk("rst_rf_valid", 64'(rf_req_valid_o), 64'd0);
      chk("rst_eu_valid", 64'(eu_valid_o), 64'd0);
    end
    rst_ni = 1'b1;
    tick;

    // two operands, RF always ready, response in the handshake cycle
    disp(3'd3, 32'h100, 2'b11, 6'd5, 6'd9);
    tick; disp_valid_i = 1'b0;
    chk("t2_n1_valid", 64'(rf_req_valid_o), 64'd1);
    chk("t2_n1_reg", 64'(rf_req_reg_o), 64'd5);
    chk("t2_n1_slot", 64'(rf_req_operand_o), 64'd0);
    rf_req_ready_i = 1'b1; rsp(1'b1, 1'b0, 32'hA0A0_0005);
    tick;
    chk("t2_n2_reg", 64'(rf_req_reg_o), 64'd9);
    chk("t2_n2_slot", 64'(rf_req_operand_o), 64'd1);
    chk("t2_n2_eu", 64'(eu_valid_o), 64'd0);
    rsp(1'b1, 1'b1, 32'hB0B0_0009);
    tick; rf_req_ready_i = 1'b0; rsp(1'b0, 1'b0, 32'h0);
    chk("t2_n3_eu", 64'(eu_valid_o), 64'd1);
    chk("t2_tag", 64'(eu_tag_o), 64'd3);
    chkd("t2_op0", eu_operands_o[0], mk(32'hA0A0_0005));
    chkd("t2_op1", eu_operands_o[1], mk(32'hB0B0_0009));
    eu_ready_i = 1'b1; tick; eu_ready_i = 1'b0;
    chk("t2_idle", 64'(opc_ready_o), 64'd1);

    // no operands: straight to issue, data zero
    disp(3'd5, 32'h140, 2'b00, 6'd1, 6'd2);
    tick; disp_valid_i = 1'b0;
    chk("t3_eu", 64'(eu_valid_o), 64'd1);
    chk("t3_rf", 64'(rf_req_valid_o), 64'd0);
    chkd("t3_op0", eu_operands_o[0], '0);
    chkd("t3_op1", eu_operands_o[1], '0);
    tick;
    chk("t3_opc_hold", 64'(opc_ready_o), 64'd0);
    eu_ready_i = 1'b1; tick; eu_ready_i = 1'b0;
    chk("t3_opc_back", 64'(opc_ready_o), 64'd1);

    // slot 1 only, RF back-pressures four cycles
    disp(3'd1, 32'h180, 2'b10, 6'd0, 6'd12);
    tick; disp_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_valid", 64'(rf_req_valid_o), 64'd1);
      chk("t4_reg", 64'(rf_req_reg_o), 64'd12);
      chk("t4_slot", 64'(rf_req_operand_o), 64'd1);
      tick;
    end
    rf_req_ready_i = 1'b1; tick; rf_req_ready_i = 1'b0;
    chk("t4_noreq", 64'(rf_req_valid_o), 64'd0);
    chk("t4_noeu", 64'(eu_valid_o), 64'd0);
    rsp(1'b1, 1'b1, 32'hC0DE_0012);
    tick; rsp(1'b0, 1'b0, 32'h0);
    chk("t4_eu", 64'(eu_valid_o), 64'd1);
    chkd("t4_op0", eu_operands_o[0], '0);
    chkd("t4_op1", eu_operands_o[1], mk(32'hC0DE_0012));
    eu_ready_i = 1'b1; tick; eu_ready_i = 1'b0;

    // out-of-order responses with a duplicate for slot 1
    disp(3'd7, 32'h1C0, 2'b11, 6'd3, 6'd4);
    tick; disp_valid_i = 1'b0;
    rf_req_ready_i = 1'b1; tick; tick; rf_req_ready_i = 1'b0;
    rsp(1'b1, 1'b1, 32'h1111_0004); tick;
    rsp(1'b1, 1'b1, 32'h2222_0004);
    chk("t5_wait1", 64'(eu_valid_o), 64'd0);
    tick;
    rsp(1'b1, 1'b0, 32'h3333_0003);
    chk("t5_wait2", 64'(eu_valid_o), 64'd0);
    tick; rsp(1'b0, 1'b0, 32'h0);
    chk("t5_eu", 64'(eu_valid_o), 64'd1);
    chkd("t5_op0", eu_operands_o[0], mk(32'h3333_0003));
    chkd("t5_op1", eu_operands_o[1], mk(32'h1111_0004));
    eu_ready_i = 1'b1; tick; eu_ready_i = 1'b0;

    // eu stall with a dispatch pending, then reset in the middle of collect
    disp(3'd6, 32'h200, 2'b00, 6'd0, 6'd0);
    tick;
    disp(3'd2, 32'h240, 2'b01, 6'd8, 6'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t6_eu_hold", 64'(eu_valid_o), 64'd1);
      chk("t6_tag_hold", 64'(eu_tag_o), 64'd6);
      chk("t6_opc_low", 64'(opc_ready_o), 64'd0);
      tick;
    end
    eu_ready_i = 1'b1; tick; eu_ready_i = 1'b0;
    chk("t6_idle", 64'(opc_ready_o), 64'd1);
    tick; disp_valid_i = 1'b0;
    chk("t6_coll_reg", 64'(rf_req_reg_o), 64'd8);
    chk("t6_coll_tag", 64'(eu_tag_o), 64'd2);
    rf_req_ready_i = 1'b1; tick; rf_req_ready_i = 1'b0;
    rst_ni = 1'b0; tick; rst_ni = 1'b1;
    chk("t6_rst_opc", 64'(opc_ready_o), 64'd1);
    chk("t6_rst_rf", 64'(rf_req_valid_o), 64'd0);
    chk("t6_rst_tag", 64'(eu_tag_o), 64'd0);
    rsp(1'b1, 1'b0, 32'hDEAD_0008);
    tick; rsp(1'b0, 1'b0, 32'h0);
    chk("t6_late_eu", 64'(eu_valid_o), 64'd0);
    chkd("t6_late_op0", eu_operands_o[0], '0);
    tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
